// File: rtl/pio_cond_pkg.sv
// -----------------------------------------------------------------------------
// pio_cond_pkg
// Shared definitions for the PIO input conditioner:
//   deb_state_e   - per-channel debounce FSM state {STABLE, COUNTING}
//   MIN_DEBOUNCE  - smallest legal DEBOUNCE_CYCLES value
//   cnt_width()   - width of the qualification counter for a given cycle count
// -----------------------------------------------------------------------------
package pio_cond_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_e;

  localparam int unsigned MIN_DEBOUNCE = 2;

  // Counter must be able to hold DEBOUNCE_CYCLES itself without wrapping.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage : pio_cond_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One conditioned input: 2-flop synchronizer, counter-based debounce FSM and
// registered single-cycle edge strobes on the clean value.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   raw_i    raw pin, asynchronous to clk_i
//   clean_o  debounced level (reset value RESET_LEVEL)
//   rise_o   1-cycle strobe, clean went 0 -> 1
//   fall_o   1-cycle strobe, clean went 1 -> 0
// -----------------------------------------------------------------------------
module debounce_channel
  import pio_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Synchronizer: plain flop chain, nothing between the stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // cnt counts consecutive cycles the synchronized level has disagreed with
  // the clean value; the first disagreeing cycle loads 1, so the update fires
  // on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync2_q != clean_q) begin
          state_d = COUNTING;
          cnt_d   = CNT_ONE;
        end
      end
      COUNTING: begin
        if (sync2_q == clean_q) begin
          // Bounce: drop the partial qualification entirely.
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE;
          cnt_d   = '0;
          clean_d = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule : debounce_channel

// File: rtl/pio_input_conditioner.sv
// -----------------------------------------------------------------------------
// pio_input_conditioner
// Synchronizes and debounces the board switches and push-buttons ahead of the
// switch/button PIOs. Clean outputs keep board polarity.
// Ports:
//   clk_clk        system clock (PIO clock)
//   reset_reset_n  asynchronous active-low reset
//   sw_raw         raw switch pins
//   btn_raw        raw button pins, idle level BTN_IDLE
//   sw_clean       debounced switches
//   btn_clean      debounced buttons
//   btn_press      1-cycle strobe, button clean value went idle -> active
//   btn_release    1-cycle strobe, button clean value went active -> idle
//   any_change     1-cycle strobe, any clean value updated this cycle
// -----------------------------------------------------------------------------
module pio_input_conditioner
  import pio_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned N_SW            = 3,
  parameter int unsigned N_BTN           = 2,
  parameter logic        BTN_IDLE        = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_change
);

  if (DEBOUNCE_CYCLES < MIN_DEBOUNCE) begin : g_bad_debounce
    $error("pio_input_conditioner: DEBOUNCE_CYCLES must be at least %0d", MIN_DEBOUNCE);
  end

  logic [N_SW-1:0]  sw_rise, sw_fall;
  logic [N_BTN-1:0] btn_rise, btn_fall;

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b0)
    ) u_ch (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .raw_i   (sw_raw[gi]),
      .clean_o (sw_clean[gi]),
      .rise_o  (sw_rise[gi]),
      .fall_o  (sw_fall[gi])
    );
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (BTN_IDLE)
    ) u_ch (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .raw_i   (btn_raw[gi]),
      .clean_o (btn_clean[gi]),
      .rise_o  (btn_rise[gi]),
      .fall_o  (btn_fall[gi])
    );
  end

  // Active-low buttons press on a falling clean edge; active-high on rising.
  if (BTN_IDLE) begin : g_idle_high
    assign btn_press   = btn_fall;
    assign btn_release = btn_rise;
  end else begin : g_idle_low
    assign btn_press   = btn_rise;
    assign btn_release = btn_fall;
  end

  // Inputs are registered strobes, so this OR stays a clean 1-cycle pulse.
  assign any_change = |{sw_rise, sw_fall, btn_rise, btn_fall};

endmodule : pio_input_conditioner

// File: tb/tb_pio_input_conditioner.sv
module tb_pio_input_conditioner;

  localparam int D    = 16;
  localparam int NSW  = 3;
  localparam int NBTN = 2;
  localparam int NCH  = NSW + NBTN;
  localparam logic BTN_IDLE = 1'b1;
  localparam logic [NCH-1:0] RST_LVL = {{NBTN{BTN_IDLE}}, {NSW{1'b0}}};

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NSW-1:0]  sw_raw = '0;
  logic [NBTN-1:0] btn_raw = {NBTN{BTN_IDLE}};
  logic [NSW-1:0]  sw_clean;
  logic [NBTN-1:0] btn_clean, btn_press, btn_release;
  logic            any_change;

  always #5 clk = ~clk;

  pio_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .N_SW            (NSW),
    .N_BTN           (NBTN),
    .BTN_IDLE        (BTN_IDLE)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .sw_raw        (sw_raw),
    .btn_raw       (btn_raw),
    .sw_clean      (sw_clean),
    .btn_clean     (btn_clean),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .any_change    (any_change)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Channel vector layout {btn, sw}. A raw level reaches the debouncer two
  // edges after it is sampled; the clean value adopts it once it has been
  // seen differing on D consecutive edges.
  logic [NCH-1:0] m_clean;
  logic [NCH-1:0] m_upd;
  logic [NCH-1:0] m_delay[$];
  int             m_run[NCH];

  task automatic model_reset();
    m_clean = RST_LVL;
    m_upd   = '0;
    m_delay = {RST_LVL, RST_LVL};
    for (int c = 0; c < NCH; c++) m_run[c] = 0;
  endtask

  initial begin
    logic [NCH-1:0] seen;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        seen = m_delay.pop_front();
        m_delay.push_back({btn_raw, sw_raw});
        m_upd = '0;
        for (int c = 0; c < NCH; c++) begin
          m_run[c] = (seen[c] != m_clean[c]) ? m_run[c] + 1 : 0;
          if (m_run[c] == D) begin
            m_clean[c] = seen[c];
            m_upd[c]   = 1'b1;
            m_run[c]   = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of the whole output bundle against the model.
  initial begin
    logic [NBTN-1:0] e_btn, e_upd, e_press, e_rel;
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      e_btn   = m_clean[NCH-1:NSW];
      e_upd   = m_upd[NCH-1:NSW];
      e_press = e_upd & (e_btn ^ {NBTN{BTN_IDLE}});
      e_rel   = e_upd & ~(e_btn ^ {NBTN{BTN_IDLE}});
      check("model_cycle",
            {22'd0, sw_clean, btn_clean, btn_press, btn_release, any_change},
            {22'd0, m_clean[NSW-1:0], e_btn, e_press, e_rel, |m_upd});
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int strobes;

  task automatic count_strobes(input int n);
    repeat (n) begin
      @(negedge clk);
      if (any_change || (|btn_press) || (|btn_release)) strobes++;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // Idle after reset: nothing moves.
    strobes = 0;
    count_strobes(100);
    check("idle_strobes", strobes, 0);
    check("idle_sw_clean", sw_clean, 3'b000);
    check("idle_btn_clean", btn_clean, 2'b11);

    // Button 0 press and release, exact latency.
    btn_raw[0] = 1'b0;
    tick(17);
    check("press_early_clean", btn_clean, 2'b11);
    tick(1);
    check("press_clean", btn_clean, 2'b10);
    check("press_strobe", btn_press, 2'b01);
    check("press_any", any_change, 1);
    tick(1);
    check("press_one_cycle", {btn_press, any_change}, 3'b000);
    tick(10);
    btn_raw[0] = 1'b1;
    tick(17);
    check("release_early_clean", btn_clean, 2'b10);
    tick(1);
    check("release_strobe", btn_release, 2'b01);
    check("release_clean", btn_clean, 2'b11);
    tick(5);

    // Button 1 bouncing every 5 cycles is rejected.
    strobes = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) btn_raw[1] = ~btn_raw[1];
      count_strobes(1);
    end
    btn_raw[1] = 1'b1;
    count_strobes(30);
    check("bounce_strobes", strobes, 0);
    check("bounce_clean", btn_clean[1], 1'b1);

    // Switches high through reset release.
    @(negedge clk); #1 rst_n = 1'b0;
    sw_raw = 3'b101;
    tick(3);
    rst_n = 1'b1;
    tick(17);
    check("sw_init_early", sw_clean, 3'b000);
    tick(1);
    check("sw_init_clean", sw_clean, 3'b101);
    check("sw_init_any", any_change, 1);
    strobes = 0;
    count_strobes(40);
    check("sw_init_single", strobes, 0);

    // Simultaneous switch and button qualification.
    sw_raw[1]  = 1'b1;
    btn_raw[0] = 1'b0;
    tick(18);
    check("simul_sw", sw_clean, 3'b111);
    check("simul_btn", btn_clean, 2'b10);
    check("simul_any", {btn_press, any_change}, 3'b011);
    tick(1);
    check("simul_any_once", any_change, 0);
    btn_raw[0] = 1'b1;
    tick(30);

    // Reset while button 0 is mid-qualification (cnt = 10).
    btn_raw[0] = 1'b0;
    tick(12);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_clean", btn_clean, 2'b11);
    check("rst_mid_press", btn_press, 2'b00);
    check("rst_mid_sw", sw_clean, 3'b000);
    tick(2);
    rst_n = 1'b1;
    tick(17);
    check("rst_requal_early", btn_clean, 2'b11);
    tick(1);
    check("rst_requal_clean", btn_clean, 2'b10);
    check("rst_requal_press", btn_press, 2'b01);
    tick(5);

    // Random phase: slow then fast toggling, occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      int unsigned span;
      span = (i < 1500) ? 40 : 8;
      for (int c = 0; c < NSW; c++)
        if ($urandom_range(span - 1) == 0) sw_raw[c] = ~sw_raw[c];
      for (int c = 0; c < NBTN; c++)
        if ($urandom_range(span - 1) == 0) btn_raw[c] = ~btn_raw[c];
      if ($urandom_range(499) == 0) begin
        #1 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end else begin
        tick(1);
      end
    end
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pio_input_conditioner
